pmc_ac_serial: RTL and testbench
================================

// Module: pmc_ac_serial
// PURPOSE
// - Parametrised analog-configuration register bank for the pixel matrix controller; successor to the fixed 4x32 bank.
// - Ibex data-bus slave; NUM_REGS x 32-bit shadow registers with byte-enable writes, plus CTRL/STATUS registers.
// - On APPLY, snapshots the shadow bank, shifts it serially into the analog config chain, then updates parallel res atomically.
// PARAMETERS
// - NUM_REGS   4   number of 32-bit config words (1..64); chain length N = NUM_REGS*32
// - CLK_DIV    2   clk cycles per ser_clk half-period (>=1)
// - ADDR_W     8   byte-address bits decoded from addr; must cover (NUM_REGS+2)*4 bytes
// PORTS
// - clk       in   1          system clock
// - rst_n     in   1          asynchronous active-low reset
// - req       in   1          bus request
// - we        in   1          write enable (valid with req)
// - be        in   4          byte enables (valid with req & we)
// - addr      in   32         byte address; word index = addr[ADDR_W-1:2]
// - wdata     in   32         write data
// - gnt       out  1          grant, combinational = req
// - rvalid    out  1          response valid, one cycle after gnt
// - rdata     out  32         read data, registered, valid with rvalid
// - res       out  N          committed analog configuration (word k at bits 32k+31:32k)
// - ser_clk   out  1          serial chain clock
// - ser_data  out  1          serial chain data, MSB (bit N-1) first
// - ser_load  out  1          chain latch strobe
// - busy      out  1          serialisation in progress
// BEHAVIOUR
// - Reset (clk, rst_n async active-low): shadow, snapshot, res, rdata, rvalid, ser_*, busy, done all 0; FSM IDLE.
// - Map (word idx): 0..NUM_REGS-1 shadow; NUM_REGS = CTRL; NUM_REGS+1 = STATUS; others: writes ignored, reads 0.
// - gnt = req every cycle (no wait states); rvalid <= req; rdata <= selected value for reads, 0 for writes.
// - Shadow write: byte i updated iff be[i]; allowed while busy (affects next APPLY only).
// - CTRL bit0 APPLY: write 1 starts a transfer if IDLE; ignored while busy; reads 0 (self-clearing).
// - STATUS: bit0 busy (RO), bit1 done (sticky, W1C); done set on STROBE exit; same-cycle set and clear -> set wins.
// - FSM IDLE -> LOAD (1 cycle: snapshot <= shadow, bit counter <= N-1, busy=1)
//   -> SHIFT: per bit, ser_data <= snapshot[cnt] with ser_clk=0 for CLK_DIV cycles, ser_clk=1 for CLK_DIV cycles;
//      cnt decrements after the high phase; after bit 0's high phase -> STROBE.
//   -> STROBE: ser_clk=0, ser_load=1 for CLK_DIV cycles; res <= snapshot on STROBE entry; exit -> IDLE, busy=0, done=1.
// - Latency: APPLY write at cycle t -> busy=1 at t+1; busy=0 at t+2+2*CLK_DIV*N+CLK_DIV.
// - res changes only on STROBE entry (never partially); ser_data held 0 outside SHIFT.
// - Reading shadow returns shadow, not committed res; committed value readable only via res port.
// - Reset mid-transfer: immediate abort, all outputs to reset values, no ser_load pulse, res cleared.
// STRUCTURE
// - Package pmc_ac_serial_pkg: FSM state enum (IDLE/LOAD/SHIFT/STROBE), CTRL/STATUS bit positions,
//   function returning CTRL/STATUS word index from NUM_REGS.
// - Sub-module pmc_ac_serializer: FSM, clock divider, bit counter, snapshot and res registers;
//   top holds bus decode, shadow bank, CTRL/STATUS and readout mux.
// TESTING
// - Reset then read every word incl. CTRL/STATUS/out-of-range -> all rdata 0, rvalid exactly 1 cycle after each req.
// - Write 0xA5A5A5A5 to reg1 with be=4'b0101 over 0x12345678 -> read 0x12A556A5; res unchanged (0).
// - NUM_REGS=2, CLK_DIV=1: shadow={0x80000001,0x00000003}, APPLY -> 64 ser_clk rising edges, sampled stream
//   1,0..0,1,0..0,1,1 (MSB first), one ser_load pulse of 1 cycle, res=0x80000001_00000003, done=1.
// - APPLY while busy, and shadow write while busy -> transfer unaffected; second APPLY after done shifts new data.
// - Write STATUS 0x2 -> done cleared; write STATUS 0x2 in the cycle done sets -> done stays 1.
// - Assert rst_n low mid-SHIFT -> ser_clk/ser_data/ser_load/busy/res 0 asynchronously, FSM IDLE, no load pulse after release.

Source files
------------

// File: rtl/pmc_ac_serial_pkg.sv
// Shared types and register-map helpers for the analog-configuration serial bank.
// The CTRL and STATUS words sit directly above the shadow bank.

package pmc_ac_serial_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StStrobe
    } ser_state_e;

    localparam int unsigned CtrlApplyBit  = 0;
    localparam int unsigned StatusBusyBit = 0;
    localparam int unsigned StatusDoneBit = 1;

    function automatic int unsigned ctrl_idx(input int unsigned num_regs);
        return num_regs;
    endfunction

    function automatic int unsigned status_idx(input int unsigned num_regs);
        return num_regs + 1;
    endfunction

endpackage

// File: rtl/pmc_ac_serial_if.sv
// Ibex-style data-bus bundle between a core (master) and the config bank (slave).

interface pmc_ac_serial_if;
    import pmc_ac_serial_pkg::*;

    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/pmc_ac_serializer.sv
// Snapshots the shadow bank, shifts it MSB-first into the analog chain, then pulses the
// latch strobe. The committed copy on res_o is updated in one step on strobe entry.

module pmc_ac_serializer
    import pmc_ac_serial_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned CLK_DIV  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [NUM_REGS*32-1:0]   shadow_i,
    output logic [NUM_REGS*32-1:0]   res_o,
    output logic                     ser_clk_o,
    output logic                     ser_data_o,
    output logic                     ser_load_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int unsigned N    = NUM_REGS * 32;
    localparam int unsigned CntW = $clog2(N);
    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] CntTop  = CntW'(N - 1);

    ser_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic [DivW-1:0] div_q;
    logic [N-1:0]    snap_q;
    logic [N-1:0]    res_q;
    logic            ser_clk_q;
    logic            ser_data_q;
    logic            ser_load_q;
    logic            busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_q      <= '0;
            snap_q     <= '0;
            res_q      <= '0;
            ser_clk_q  <= 1'b0;
            ser_data_q <= 1'b0;
            ser_load_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StLoad;
                        busy_q  <= 1'b1;
                    end
                end
                StLoad: begin
                    snap_q     <= shadow_i;
                    cnt_q      <= CntTop;
                    div_q      <= '0;
                    ser_clk_q  <= 1'b0;
                    ser_data_q <= shadow_i[N-1];
                    state_q    <= StShift;
                end
                StShift: begin
                    if (div_q == DivLast) begin
                        div_q <= '0;
                        if (!ser_clk_q) begin
                            ser_clk_q <= 1'b1;
                        end else begin
                            // End of a bit's high phase: advance or commit.
                            ser_clk_q <= 1'b0;
                            if (cnt_q == '0) begin
                                ser_data_q <= 1'b0;
                                ser_load_q <= 1'b1;
                                res_q      <= snap_q;
                                state_q    <= StStrobe;
                            end else begin
                                cnt_q      <= cnt_q - CntW'(1);
                                ser_data_q <= snap_q[cnt_q - CntW'(1)];
                            end
                        end
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end
                StStrobe: begin
                    if (div_q == DivLast) begin
                        div_q      <= '0;
                        ser_load_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Asserted in the last strobe cycle so STATUS.done sets on the same edge busy drops.
    assign done_o     = (state_q == StStrobe) && (div_q == DivLast);
    assign res_o      = res_q;
    assign ser_clk_o  = ser_clk_q;
    assign ser_data_o = ser_data_q;
    assign ser_load_o = ser_load_q;
    assign busy_o     = busy_q;

endmodule

// File: rtl/pmc_ac_serial.sv
// Analog-configuration register bank: bus decode, byte-enabled shadow words, CTRL/STATUS
// and read mux; serialisation of the committed configuration is delegated to the serializer.

module pmc_ac_serial
    import pmc_ac_serial_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pmc_ac_serial_if.slave         bus_io,
    output logic [NUM_REGS*32-1:0] res_o,
    output logic                   ser_clk_o,
    output logic                   ser_data_o,
    output logic                   ser_load_o,
    output logic                   busy_o
);

    localparam int unsigned CtrlIdx   = ctrl_idx(NUM_REGS);
    localparam int unsigned StatusIdx = status_idx(NUM_REGS);

    logic [NUM_REGS-1:0][31:0] shadow_q, shadow_d;
    logic                      done_q, done_d;
    logic                      rvalid_q;
    logic [31:0]               rdata_q, rdata_d;
    logic [31:0]               rd_val;
    logic [31:0]               word_idx;
    logic                      wr, is_ctrl, is_status;
    logic                      start, done_clr, ser_done, busy;

    assign word_idx  = 32'(bus_io.addr[ADDR_W-1:2]);
    assign wr        = bus_io.req & bus_io.we;
    assign is_ctrl   = (word_idx == CtrlIdx);
    assign is_status = (word_idx == StatusIdx);
    assign start     = wr & is_ctrl & bus_io.be[0] & bus_io.wdata[CtrlApplyBit];
    assign done_clr  = wr & is_status & bus_io.be[0] & bus_io.wdata[StatusDoneBit];

    if (ADDR_W < 32) begin : g_unused_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus_io.addr[31:ADDR_W];
    end
    logic unused_addr_lo;
    assign unused_addr_lo = ^bus_io.addr[1:0];

    always_comb begin
        shadow_d = shadow_q;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (wr && (word_idx == k)) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (bus_io.be[b]) shadow_d[k][8*b +: 8] = bus_io.wdata[8*b +: 8];
                end
            end
        end
    end

    // Set wins over a simultaneous W1C.
    always_comb begin
        done_d = done_q;
        if (done_clr) done_d = 1'b0;
        if (ser_done) done_d = 1'b1;
    end

    always_comb begin
        rd_val = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (word_idx == k) rd_val = shadow_q[k];
        end
        if (is_status) begin
            rd_val[StatusBusyBit] = busy;
            rd_val[StatusDoneBit] = done_q;
        end
        rdata_d = (bus_io.req && !bus_io.we) ? rd_val : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            done_q   <= done_d;
            rvalid_q <= bus_io.req;
            rdata_q  <= rdata_d;
        end
    end

    assign bus_io.gnt    = bus_io.req;
    assign bus_io.rvalid = rvalid_q;
    assign bus_io.rdata  = rdata_q;

    pmc_ac_serializer #(
        .NUM_REGS (NUM_REGS),
        .CLK_DIV  (CLK_DIV)
    ) u_serializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .shadow_i   (shadow_q),
        .res_o      (res_o),
        .ser_clk_o  (ser_clk_o),
        .ser_data_o (ser_data_o),
        .ser_load_o (ser_load_o),
        .busy_o     (busy),
        .done_o     (ser_done)
    );

    assign busy_o = busy;

endmodule

// File: tb/tb_pmc_ac_serial.sv
// Directed self-checking bench for pmc_ac_serial with NUM_REGS=2, CLK_DIV=1.

module tb_pmc_ac_serial;

    localparam int unsigned NumRegs = 2;
    localparam int unsigned ClkDiv  = 1;
    localparam int unsigned AddrW   = 8;
    localparam int unsigned N       = NumRegs * 32;
    localparam int unsigned BusyLen = 1 + 2 * ClkDiv * N + ClkDiv;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pmc_ac_serial_if bus ();
    logic [N-1:0] res;
    logic ser_clk, ser_data, ser_load, busy;

    pmc_ac_serial #(
        .NUM_REGS (NumRegs),
        .CLK_DIV  (ClkDiv),
        .ADDR_W   (AddrW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_io     (bus),
        .res_o      (res),
        .ser_clk_o  (ser_clk),
        .ser_data_o (ser_data),
        .ser_load_o (ser_load),
        .busy_o     (busy)
    );

    int passes = 0;
    int total  = 0;

    logic [63:0] stream;
    int clk_edges, load_cycles, load_pulses, busy_cycles;
    logic load_prev = 1'b0;

    always @(posedge ser_clk) begin
        stream = {stream[62:0], ser_data};
        clk_edges++;
    end

    always @(negedge clk) begin
        if (ser_load) load_cycles++;
        if (ser_load && !load_prev) load_pulses++;
        load_prev = ser_load;
        if (busy) busy_cycles++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic reset_mon();
        stream      = '0;
        clk_edges   = 0;
        load_cycles = 0;
        load_pulses = 0;
        busy_cycles = 0;
    endtask

    task automatic drive(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.req   = 1'b1;
        bus.we    = we;
        bus.be    = be;
        bus.addr  = addr;
        bus.wdata = wdata;
    endtask

    task automatic idle();
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.be    = 4'h0;
        bus.addr  = '0;
        bus.wdata = '0;
    endtask

    task automatic bus_op(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag,
                          output logic [31:0] rd);
        @(negedge clk);
        drive(we, be, addr, wdata);
        #1 chk({tag, "_gnt"}, 64'(bus.gnt), 64'd1);
        @(negedge clk);
        chk({tag, "_rvalid"}, 64'(bus.rvalid), 64'd1);
        rd = bus.rdata;
        idle();
        @(negedge clk);
        chk({tag, "_rvalid_drop"}, 64'(bus.rvalid), 64'd0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        logic [31:0] rd;
        bus_op(1'b1, be, addr, data, "wr", rd);
    endtask

    task automatic rd_chk(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        bus_op(1'b0, 4'hf, addr, 32'h0, tag, rd);
        chk(tag, 64'(rd), 64'(exp));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        idle();
        reset_mon();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_res", 64'(res), 64'd0);
        chk("rst_ser", 64'({ser_clk, ser_data, ser_load, busy}), 64'd0);
        rd_chk(32'h00, 32'h0, "rst_w0");
        rd_chk(32'h04, 32'h0, "rst_w1");
        rd_chk(32'h08, 32'h0, "rst_ctrl");
        rd_chk(32'h0c, 32'h0, "rst_status");
        rd_chk(32'h14, 32'h0, "rst_oor14");
        rd_chk(32'hfc, 32'h0, "rst_oorfc");

        // Byte-enable merge.
        wr(32'h04, 32'h12345678, 4'hf);
        wr(32'h04, 32'ha5a5a5a5, 4'b0101);
        rd_chk(32'h04, 32'h12a556a5, "be_merge");
        chk("be_res_unchanged", 64'(res), 64'd0);

        // First transfer: {0x80000001, 0x00000003}.
        wr(32'h00, 32'h00000003, 4'hf);
        wr(32'h04, 32'h80000001, 4'hf);
        reset_mon();
        wr(32'h08, 32'h1, 4'hf);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_res_mid", 64'(res), 64'd0);
        wait_idle();
        chk("t1_edges", 64'(clk_edges), 64'd64);
        chk("t1_stream", stream, 64'h80000001_00000003);
        chk("t1_load_pulses", 64'(load_pulses), 64'd1);
        chk("t1_load_cycles", 64'(load_cycles), 64'(ClkDiv));
        chk("t1_busy_cycles", 64'(busy_cycles), 64'(BusyLen));
        chk("t1_res", 64'(res), 64'h80000001_00000003);
        chk("t1_idle_ser", 64'({ser_clk, ser_data, ser_load}), 64'd0);
        rd_chk(32'h08, 32'h0, "ctrl_selfclear");
        rd_chk(32'h0c, 32'h2, "t1_done");

        wr(32'h0c, 32'h2, 4'hf);
        rd_chk(32'h0c, 32'h0, "done_w1c");

        // Second transfer with APPLY and shadow writes while busy.
        wr(32'h04, 32'hc0000000, 4'hf);
        wr(32'h00, 32'h00000000, 4'hf);
        reset_mon();
        wr(32'h08, 32'h1, 4'hf);
        wr(32'h04, 32'h12345678, 4'hf);
        wr(32'h08, 32'h1, 4'hf);
        rd_chk(32'h0c, 32'h1, "t2_status_busy");
        wait_idle();
        chk("t2_stream", stream, 64'hc0000000_00000000);
        chk("t2_edges", 64'(clk_edges), 64'd64);
        chk("t2_busy_cycles", 64'(busy_cycles), 64'(BusyLen));
        chk("t2_load_pulses", 64'(load_pulses), 64'd1);
        chk("t2_res", 64'(res), 64'hc0000000_00000000);
        rd_chk(32'h04, 32'h12345678, "shadow_not_res");

        // Third transfer: W1C lands in the same cycle done sets.
        wr(32'h0c, 32'h2, 4'hf);
        reset_mon();
        @(negedge clk);
        drive(1'b1, 4'hf, 32'h08, 32'h1);
        @(negedge clk);
        idle();
        repeat (BusyLen - 1) @(negedge clk);
        chk("t3_busy_last", 64'(busy), 64'd1);
        drive(1'b1, 4'hf, 32'h0c, 32'h2);
        @(negedge clk);
        idle();
        chk("t3_busy_drop", 64'(busy), 64'd0);
        rd_chk(32'h0c, 32'h2, "done_set_wins");
        chk("t3_stream", stream, 64'h12345678_00000000);
        chk("t3_res", 64'(res), 64'h12345678_00000000);

        // Asynchronous reset mid-shift.
        reset_mon();
        wr(32'h08, 32'h1, 4'hf);
        repeat (20) @(negedge clk);
        chk("t4_busy_mid", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_ser", 64'({ser_clk, ser_data, ser_load, busy}), 64'd0);
        chk("t4_rst_res", 64'(res), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_mon();
        repeat (200) @(negedge clk);
        chk("t4_no_load", 64'(load_cycles), 64'd0);
        chk("t4_no_edges", 64'(clk_edges), 64'd0);
        chk("t4_idle", 64'(busy), 64'd0);
        rd_chk(32'h0c, 32'h0, "t4_status");
        rd_chk(32'h04, 32'h0, "t4_shadow");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
